// File: rtl/compute_unit_if.sv
// compute_unit_if: operand/result bundle between the conv datapath and the MAC unit
interface compute_unit_if;
    logic [31:0] floatA;
    logic [31:0] floatB;
    logic [31:0] result;
    modport master (output floatA, output floatB, input result);
    modport slave (input floatA, input floatB, output result);
endinterface

// File: rtl/compute_unit.sv
// compute_unit: binary32 multiply-accumulate, combinational mul+add into one accumulator register
module compute_unit (
    input  logic           clk,
    input  logic           reset,
    compute_unit_if.slave  bus
);
    function automatic logic [4:0] lzc(input logic [26:0] v);
        lzc = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc = 5'(26 - i);
    endfunction
    logic [31:0] acc, nxt, prd, sum;
    logic        sa, sb, sc, ps;
    logic [7:0]  ea, eb, ec;
    logic [22:0] fa, fb, fc;
    logic        za, zb, zc, ia, ib, ic, na, nb, nc;
    assign {sa, ea, fa} = bus.floatA;
    assign {sb, eb, fb} = bus.floatB;
    assign {sc, ec, fc} = acc;
    assign za = ea == 8'h00;
    assign zb = eb == 8'h00;
    assign zc = ec == 8'h00;
    assign ia = ea == 8'hFF && fa == 23'h0;
    assign ib = eb == 8'hFF && fb == 23'h0;
    assign ic = ec == 8'hFF && fc == 23'h0;
    assign na = ea == 8'hFF && fa != 23'h0;
    assign nb = eb == 8'hFF && fb != 23'h0;
    assign nc = ec == 8'hFF && fc != 23'h0;
    logic [47:0]        prod;
    logic [22:0]        pfr;
    logic [23:0]        pf;
    logic               pg, pst, p_inf, p_zero, nan;
    logic signed [9:0]  pe, pex;
    // Hidden bit is always set, so a carry out of the fraction is the rounding carry.
    always_comb begin
        prod = 48'({1'b1, fa}) * 48'({1'b1, fb});
        pe = {2'b0, ea} + {2'b0, eb} - 10'd127 + {9'b0, prod[47]};
        pfr = prod[47] ? prod[46:24] : prod[45:23];
        pg = prod[47] ? prod[23] : prod[22];
        pst = prod[47] ? |prod[22:0] : |prod[21:0];
        pf = {1'b0, pfr} + {23'b0, pg & (pst | pfr[0])};
        pex = pe + {9'b0, pf[23]};
        ps = sa ^ sb;
        p_inf = ia | ib | (!za && !zb && pex >= 255);
        p_zero = !p_inf && (za || zb || pex <= 0);
        nan = na | nb | nc | (ia & zb) | (ib & za) | (p_inf & ic & (ps != sc));
        prd = {ps, pex[7:0], pf[22:0]};
    end
    logic               swap, sx, sy;
    logic [7:0]         ex, ey, d;
    logic [22:0]        fx, fy;
    logic [49:0]        yw;
    logic [26:0]        x27, y27, n;
    logic [27:0]        s;
    logic [4:0]         lz;
    logic [23:0]        r;
    logic signed [9:0]  se, sex;
    // x is the larger magnitude; y is aligned into guard/round/sticky below x's LSB.
    always_comb begin
        swap = {pex[7:0], pf[22:0]} > {ec, fc};
        {sx, ex, fx} = swap ? prd : acc;
        {sy, ey, fy} = swap ? acc : prd;
        d = ex - ey;
        yw = {1'b1, fy, 26'b0} >> (d > 8'd49 ? 8'd49 : d);
        x27 = {1'b1, fx, 3'b0};
        y27 = {yw[49:24], |yw[23:0]};
        s = sx == sy ? {1'b0, x27} + {1'b0, y27} : {1'b0, x27} - {1'b0, y27};
        lz = lzc(s[26:0]);
        n = s[27] ? {s[27:2], |s[1:0]} : s[26:0] << lz;
        se = s[27] ? {2'b0, ex} + 10'd1 : {2'b0, ex} - {5'b0, lz};
        r = {1'b0, n[25:3]} + {23'b0, n[2] & (|n[1:0] | n[3])};
        sex = se + {9'b0, r[23]};
        sum = !n[26] ? 32'h0 : sex >= 255 ? {sx, 8'hFF, 23'h0} :
              sex <= 0 ? {sx, 31'h0} : {sx, sex[7:0], r[22:0]};
    end
    assign nxt = nan ? 32'h7FC0_0000 : ic ? acc : p_inf ? {ps, 8'hFF, 23'h0} :
                 p_zero ? acc : zc ? prd : sum;
    always_ff @(posedge clk or posedge reset)
        if (reset) acc <= 32'h0;
        else acc <= nxt;
    assign bus.result = acc;
endmodule

// File: tb/tb_compute_unit.sv
// tb_compute_unit: directed binary32 MAC vectors with hand-computed accumulator values
module tb_compute_unit;
    logic clk;
    logic reset;
    int vectors = 0;
    int miscompares = 0;
    compute_unit_if bus();
    compute_unit dut (.clk(clk), .reset(reset), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] want);
        vectors++;
        assert (bus.result === want)
        else begin
            miscompares++;
            $error("FAIL %s: result=%h expected=%h", tag, bus.result, want);
        end
    endtask
    task automatic step(input logic [31:0] a, input logic [31:0] b);
        bus.floatA = a;
        bus.floatB = b;
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_reset;
        reset = 1'b1;
        #1;
        chk("async_reset", 32'h0000_0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask
    initial begin
        reset = 1'b1;
        bus.floatA = 32'h0;
        bus.floatB = 32'h0;
        @(posedge clk);
        #1;
        chk("reset_state", 32'h0000_0000);
        reset = 1'b0;
        step(32'h0000_0000, 32'h0000_0000); chk("zero_hold", 32'h0000_0000);
        step(32'h40A0_0000, 32'h4020_0000); chk("mul_5x2.5", 32'h4148_0000);
        step(32'h3D4C_CCCD, 32'h4000_0000); chk("add_0.1_rne", 32'h4149_999A);
        step(32'h0000_0000, 32'h4000_0000); chk("zero_product", 32'h4149_999A);
        step(32'h3FA0_0000, 32'h40B0_0000); chk("add_6.875", 32'h419B_CCCD);
        pulse_reset;
        step(32'h3F80_0000, 32'h3F80_0000); chk("one", 32'h3F80_0000);
        step(32'hBF80_0000, 32'h3F80_0000); chk("cancel_pos_zero", 32'h0000_0000);
        step(32'h7FC0_0000, 32'h3F80_0000); chk("nan_in", 32'h7FC0_0000);
        step(32'h3F80_0000, 32'h3F80_0000); chk("nan_sticky", 32'h7FC0_0000);
        pulse_reset;
        step(32'h7F00_0000, 32'h4000_0000); chk("mul_overflow_inf", 32'h7F80_0000);
        step(32'h3F80_0000, 32'h3F80_0000); chk("inf_sticky", 32'h7F80_0000);
        step(32'hFF80_0000, 32'h3F80_0000); chk("inf_minus_inf", 32'h7FC0_0000);
        pulse_reset;
        step(32'h7F80_0000, 32'h0000_0000); chk("inf_times_zero", 32'h7FC0_0000);
        pulse_reset;
        step(32'hC000_0000, 32'h4040_0000); chk("neg_product", 32'hC0C0_0000);
        step(32'h0080_0000, 32'h3F00_0000); chk("mul_underflow", 32'hC0C0_0000);
        step(32'h0040_0000, 32'h4000_0000); chk("denormal_flush", 32'hC0C0_0000);
        step(32'h4000_0000, 32'h4000_0000); chk("sub_renorm", 32'hC000_0000);
        pulse_reset;
        step(32'h3F80_0000, 32'h3F80_0000); chk("one_again", 32'h3F80_0000);
        step(32'h3080_0000, 32'h3F80_0000); chk("tiny_sticky", 32'h3F80_0000);
        step(32'h3380_0000, 32'h3F80_0000); chk("tie_even_down", 32'h3F80_0000);
        step(32'h3400_0000, 32'h3F80_0000); chk("one_ulp", 32'h3F80_0001);
        step(32'h3380_0000, 32'h3F80_0000); chk("tie_odd_up", 32'h3F80_0002);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
